// File: rtl/rpn_evaluator_if.sv
// ============================================================================
// rpn_evaluator_if : program-ROM fetch port and fixed_point_alu command port
// Rev 1.0
// ============================================================================
`default_nettype none

interface rpn_evaluator_if #(
    parameter int NUMBER_WIDTH = 16,
    parameter int ADDR_WIDTH   = 5
);
    logic [ADDR_WIDTH-1:0]   program_addr;
    logic [NUMBER_WIDTH+1:0] program_data;
    logic                    alu_start;
    logic [2:0]              alu_op;
    logic [NUMBER_WIDTH-1:0] alu_a;
    logic [NUMBER_WIDTH-1:0] alu_b;
    logic                    alu_done;
    logic [NUMBER_WIDTH-1:0] alu_result;

    modport master (
        output program_addr,
        input  program_data,
        output alu_start,
        output alu_op,
        output alu_a,
        output alu_b,
        input  alu_done,
        input  alu_result
    );

    modport slave (
        input  program_addr,
        output program_data,
        input  alu_start,
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output alu_done,
        output alu_result
    );
endinterface

`default_nettype wire

// File: rtl/rpn_evaluator.sv
// ============================================================================
// rpn_evaluator : postfix program sequencer with operand stack driving a shared ALU
// Optional macro RPN_EVALUATOR_CYCLE_COUNT_EN adds a saturating busy-cycle counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module rpn_evaluator #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int PROGRAM_LENGTH        = 32,
    parameter int STACK_DEPTH           = 8
) (
    input  wire                                                 clk,
    input  wire                                                 rst_n,
    input  wire                                                 start,
    input  wire  [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] x,
    output logic                                                done,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result,
    output logic                                                error,
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
    output logic [15:0]                                         cycle_count,
`endif
    rpn_evaluator_if.master                                     bus
);

    localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int ADDR_WIDTH   = $clog2(PROGRAM_LENGTH);
    localparam int PC_W         = ADDR_WIDTH + 1;
    localparam int SP_W         = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [PC_W-1:0] PC_END  = PC_W'(PROGRAM_LENGTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [1:0] KIND_CONST = 2'b00;
    localparam logic [1:0] KIND_X     = 2'b01;
    localparam logic [1:0] KIND_OP    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_ALU_ISSUE  = 3'd3,
        S_ALU_SETTLE = 3'd4,
        S_ALU_WAIT   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PC_W-1:0]         r_pc;
    logic [SP_W-1:0]         r_sp;
    logic [NUMBER_WIDTH-1:0] r_x;
    logic [2:0]              r_op;
    logic [NUMBER_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic                    w_accept;
    logic                    w_push;
    logic                    w_latch_op;
    logic                    w_pop;
    logic                    w_finish;
    logic                    w_fail;
    logic [1:0]              w_kind;
    logic [NUMBER_WIDTH-1:0] w_payload;
    logic [NUMBER_WIDTH-1:0] w_push_data;
    logic [IDX_W-1:0]        w_idx_top;
    logic [IDX_W-1:0]        w_idx_a;
    logic [IDX_W-1:0]        w_idx_b;

    assign w_kind      = bus.program_data[NUMBER_WIDTH+1:NUMBER_WIDTH];
    assign w_payload   = bus.program_data[NUMBER_WIDTH-1:0];
    assign w_push_data = (w_kind == KIND_X) ? r_x : w_payload;
    assign w_idx_top   = IDX_W'(r_sp);
    assign w_idx_a     = IDX_W'(r_sp - SP_TWO);
    assign w_idx_b     = IDX_W'(r_sp - SP_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_push       = 1'b0;
        w_latch_op   = 1'b0;
        w_pop        = 1'b0;
        w_finish     = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_pc == PC_END) begin
                    w_fail       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_kind)
                    KIND_CONST, KIND_X: begin
                        if (r_sp == SP_FULL) begin
                            w_fail       = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_push       = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    end
                    KIND_OP: begin
                        // Only add/sub/mul/div exist, so op codes with bit 2 set are illegal
                        if ((r_sp < SP_TWO) || w_payload[2]) begin
                            w_fail       = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_latch_op   = 1'b1;
                            w_state_next = S_ALU_ISSUE;
                        end
                    end
                    default: begin
                        if (r_sp != SP_ONE) begin
                            w_fail = 1'b1;
                        end else begin
                            w_finish = 1'b1;
                        end
                        w_state_next = S_IDLE;
                    end
                endcase
            end
            S_ALU_ISSUE: begin
                if (bus.alu_done) begin
                    w_state_next = S_ALU_SETTLE;
                end
            end
            // The ALU still shows ready in the cycle right after start
            S_ALU_SETTLE: begin
                w_state_next = S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
                if (bus.alu_done) begin
                    w_pop        = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_sp   <= '0;
            r_x    <= '0;
            r_op   <= '0;
            result <= '0;
            error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x   <= x;
                r_pc  <= '0;
                r_sp  <= '0;
                error <= 1'b0;
            end
            if (w_push) begin
                r_sp <= r_sp + SP_ONE;
                r_pc <= r_pc + PC_ONE;
            end
            if (w_latch_op) begin
                r_op <= w_payload[2:0];
            end
            if (w_pop) begin
                r_sp <= r_sp - SP_ONE;
                r_pc <= r_pc + PC_ONE;
            end
            if (w_finish) begin
                result <= r_stack[0];
            end
            if (w_fail) begin
                result <= '0;
                error  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_idx_top] <= w_push_data;
        end else if (w_pop) begin
            r_stack[w_idx_a] <= bus.alu_result;
        end
    end

`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= 16'd0;
        end else if (w_accept) begin
            cycle_count <= 16'd0;
        end else if ((r_state != S_IDLE) && (cycle_count != 16'hFFFF)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

    assign done             = (r_state == S_IDLE);
    assign bus.program_addr = r_pc[ADDR_WIDTH-1:0];
    assign bus.alu_start    = (r_state == S_ALU_ISSUE) && bus.alu_done;
    assign bus.alu_op       = r_op;
    assign bus.alu_a        = r_stack[w_idx_a];
    assign bus.alu_b        = r_stack[w_idx_b];

endmodule

`default_nettype wire

// File: tb/tb_rpn_evaluator.sv
// ============================================================================
// tb_rpn_evaluator : directed bench with ROM and multi-cycle Q8.8 ALU stubs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rpn_evaluator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic        done;
    logic [15:0] result;
    logic        error;
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    int errors = 0;
    int checks = 0;

    rpn_evaluator_if #(.NUMBER_WIDTH(16), .ADDR_WIDTH(5)) bus ();

    rpn_evaluator #(
        .INTEGER_PART_WIDTH   (8),
        .FRACTIONAL_PART_WIDTH(8),
        .PROGRAM_LENGTH       (32),
        .STACK_DEPTH          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x          (x),
        .done       (done),
        .result     (result),
        .error      (error),
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM
    logic [17:0] rom [32];
    always @(posedge clk) bus.program_data <= rom[bus.program_addr];

    // ALU stub: ready drops after start, busy for op-dependent cycles, never reset
    logic        alu_busy = 1'b0;
    int          alu_cnt  = 0;
    logic [15:0] alu_pending = 16'h0;
    assign bus.alu_done = ~alu_busy;

    function automatic int alu_latency(input logic [2:0] op);
        case (op)
            3'd2:    return 3;
            3'd3:    return 20;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin p = {16'h0, a} * {16'h0, b}; return p[23:8]; end
            default: begin
                if (b == 16'h0) return 16'hFFFF;
                p = {8'h0, a, 8'h0} / {16'h0, b};
                return p[15:0];
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.alu_start && !alu_busy) begin
            alu_busy    <= 1'b1;
            alu_cnt     <= alu_latency(bus.alu_op);
            alu_pending <= alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
        end else if (alu_busy) begin
            if (alu_cnt == 1) begin
                alu_busy       <= 1'b0;
                bus.alu_result <= alu_pending;
            end else begin
                alu_cnt <= alu_cnt - 1;
            end
        end
    end

    int   alu_starts = 0;
    int   busy_issues = 0;
    logic mon_en = 1'b0;
    int   mon_samples = 0;
    int   mon_bad = 0;
    always @(negedge clk) begin
        if (bus.alu_start) alu_starts++;
        if (bus.alu_start && !bus.alu_done) busy_issues++;
        if (mon_en && (bus.alu_start || !bus.alu_done)) begin
            mon_samples++;
            if (bus.alu_a !== 16'h0180 || bus.alu_b !== 16'h0200 || bus.alu_op !== 3'd2) mon_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] t_const(input logic [15:0] v);
        return {2'b00, v};
    endfunction
    function automatic logic [17:0] t_x();
        return {2'b01, 16'h0};
    endfunction
    function automatic logic [17:0] t_op(input logic [2:0] op);
        return {2'b10, 13'h0, op};
    endfunction
    function automatic logic [17:0] t_end();
        return {2'b11, 16'h0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = t_end();
    endtask

    // Start one evaluation and count the cycles done stays low
    task automatic run(input logic [15:0] xv, input int pulse_at, output int cyc);
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 1000) begin
            cyc++;
            if (cyc == pulse_at) begin
                start = 1'b1;
                x     = 16'h0700;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("no_timeout", 32'(cyc < 1000), 32'd1);
    endtask

    int cyc;
    int s0;
    int wait_cnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        x     = 16'h0;
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_addr", 32'(bus.program_addr), 32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
        check("rst_cycle_count", 32'(cycle_count), 32'd0);
`endif
        rst_n = 1'b1;

        // x + 1.0
        clear_rom();
        rom[0] = t_x(); rom[1] = t_const(16'h0100); rom[2] = t_op(3'd0); rom[3] = t_end();
        s0 = alu_starts;
        run(16'h0180, 0, cyc);
        check("add_cycles", 32'(cyc), 32'd11);
        check("add_result", 32'(result), 32'h0280);
        check("add_error", 32'(error), 32'd0);
        check("add_alu_starts", 32'(alu_starts - s0), 32'd1);
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
        check("add_cycle_count", 32'(cycle_count), 32'd11);
`endif

        // x * 2.0 with operand stability watch
        rom[1] = t_const(16'h0200); rom[2] = t_op(3'd2);
        mon_en = 1'b1;
        run(16'h0180, 0, cyc);
        mon_en = 1'b0;
        check("mul_result", 32'(result), 32'h0300);
        check("mul_cycles", 32'(cyc), 32'd13);
        check("mul_stable_bad", 32'(mon_bad), 32'd0);
        check("mul_stable_samples", 32'(mon_samples), 32'd4);

        // x - 1.0 checks operand order
        rom[1] = t_const(16'h0100); rom[2] = t_op(3'd1);
        run(16'h0500, 0, cyc);
        check("sub_result", 32'(result), 32'h0400);
        check("sub_cycles", 32'(cyc), 32'd11);

        // underflow
        clear_rom();
        rom[0] = t_op(3'd0); rom[1] = t_end();
        s0 = alu_starts;
        run(16'h0100, 0, cyc);
        check("under_cycles", 32'(cyc), 32'd2);
        check("under_error", 32'(error), 32'd1);
        check("under_result", 32'(result), 32'h0);
        check("under_alu_starts", 32'(alu_starts - s0), 32'd0);

        // stack overflow on ninth push
        clear_rom();
        for (int i = 0; i < 9; i++) rom[i] = t_const(16'(i + 1));
        run(16'h0100, 0, cyc);
        check("over_cycles", 32'(cyc), 32'd18);
        check("over_error", 32'(error), 32'd1);

        // illegal op code
        clear_rom();
        rom[0] = t_x(); rom[1] = t_x(); rom[2] = t_op(3'd4); rom[3] = t_end();
        s0 = alu_starts;
        run(16'h0100, 0, cyc);
        check("illegal_cycles", 32'(cyc), 32'd6);
        check("illegal_error", 32'(error), 32'd1);
        check("illegal_alu_starts", 32'(alu_starts - s0), 32'd0);

        // END with two entries left
        rom[2] = t_end();
        run(16'h0100, 0, cyc);
        check("end_sp_cycles", 32'(cyc), 32'd6);
        check("end_sp_error", 32'(error), 32'd1);

        // program overrun: no END in all 32 slots
        clear_rom();
        rom[0] = t_x();
        for (int i = 1; i < 31; i++) rom[i] = (i % 2 == 1) ? t_const(16'h0001) : t_op(3'd0);
        rom[31] = t_const(16'h0001);
        run(16'h0100, 0, cyc);
        check("overrun_cycles", 32'(cyc), 32'd110);
        check("overrun_error", 32'(error), 32'd1);
        check("overrun_result", 32'(result), 32'h0);

        // start while busy is ignored
        clear_rom();
        rom[0] = t_x(); rom[1] = t_const(16'h0100); rom[2] = t_op(3'd0); rom[3] = t_end();
        run(16'h0180, 4, cyc);
        check("busy_start_cycles", 32'(cyc), 32'd11);
        check("busy_start_result", 32'(result), 32'h0280);
        check("busy_start_error", 32'(error), 32'd0);
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
        check("busy_start_count", 32'(cycle_count), 32'd11);
        repeat (3) @(negedge clk);
        check("idle_count_hold", 32'(cycle_count), 32'd11);
`endif

        // reset in the middle of a long divide
        rom[1] = t_const(16'h0200); rom[2] = t_op(3'd3);
        @(negedge clk);
        x     = 16'h0300;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_cnt = 0;
        while (bus.alu_done && wait_cnt < 100) begin
            wait_cnt++;
            @(negedge clk);
        end
        check("div_alu_busy_seen", 32'(wait_cnt < 100), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_addr", 32'(bus.program_addr), 32'd0);
        check("midrst_alu_start", 32'(bus.alu_start), 32'd0);
`ifdef RPN_EVALUATOR_CYCLE_COUNT_EN
        check("midrst_count", 32'(cycle_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        s0 = alu_starts;
        run(16'h0300, 0, cyc);
        check("div_result", 32'(result), 32'h0180);
        check("div_error", 32'(error), 32'd0);
        check("div_alu_starts", 32'(alu_starts - s0), 32'd1);
        check("no_issue_while_busy", 32'(busy_issues), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rpn_evaluator.md
Name: rpn_evaluator

Overview:
- Sequencer that evaluates a postfix (RPN) expression program for one x sample and returns the fixed-point result.
- Sits between the plot scan logic and the shared fixed_point_alu.
- Fetches tokens from an external synchronous program ROM and keeps an operand stack.
- Issues ALU operations through the ALU's start/done handshake.

Parameters:
- INTEGER_PART_WIDTH, 8, integer bits of the fixed-point number.
- FRACTIONAL_PART_WIDTH, 8, fractional bits; NUMBER_WIDTH = sum of both (local).
- PROGRAM_LENGTH, 32, maximum tokens; ADDR_WIDTH = clog2(PROGRAM_LENGTH) (local).
- STACK_DEPTH, 8, operand stack entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin evaluation; accepted only in IDLE.
- x  in  NUMBER_WIDTH  sample value, latched on accepted start.
- done  out  1  high in IDLE (ready / result valid).
- result  out  NUMBER_WIDTH  last evaluation result (registered).
- error  out  1  last evaluation failed (registered).
- program_addr  out  ADDR_WIDTH  ROM address = pc.
- program_data  in  NUMBER_WIDTH+2  token {kind[1:0], payload}; valid one cycle after program_addr.
- alu_start, alu_op[2:0], alu_a, alu_b  out  ALU command.
- alu_done  in  1  ALU ready level.
- alu_result  in  NUMBER_WIDTH  ALU result, valid when alu_done is high after an operation.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, pc=0, sp=0, result=0, error=0, alu_start=0.
  - Stack contents are don't-care.
  - Reset during an ALU operation abandons it; the ALU is not reset.
- Token kinds:
  - 00 PUSH_CONST: push payload.
  - 01 PUSH_X: push latched x.
  - 10 OP: payload[2:0] is the ALU op; 000 add, 001 sub, 010 mul, 011 div are legal.
  - 11 END.
- States: IDLE, FETCH, DECODE, ALU_ISSUE, ALU_SETTLE, ALU_WAIT.
- IDLE:
  - On start: latch x, pc=0, sp=0, error=0, go to FETCH.
  - start is ignored in every other state.
- FETCH: drive program_addr=pc, go to DECODE.
- DECODE (program_data valid):
  - Push token: if sp==STACK_DEPTH it is an overflow error; otherwise write, sp+1, pc+1, go to FETCH.
  - OP: if sp<2 it is an underflow error; if op>3 it is an illegal-op error; otherwise go to ALU_ISSUE.
  - END: if sp!=1 it is an error; otherwise result=stack[0], go to IDLE.
- ALU operand and op mapping:
  - alu_a = stack[sp-2], alu_b = stack[sp-1] (so "x 2 -" evaluates x-2).
  - alu_op = payload[2:0].
  - All three are held stable from ALU_ISSUE through ALU_WAIT.
- ALU_ISSUE:
  - alu_start = alu_done (combinational from state), so a command is never issued to a busy ALU.
  - Go to ALU_SETTLE once alu_done=1.
- ALU_SETTLE: one cycle; alu_done is ignored because the ALU drops ready the cycle after start. Go to ALU_WAIT.
- ALU_WAIT:
  - On alu_done=1: stack[sp-2]=alu_result, sp-1, pc+1, go to FETCH.
  - Otherwise stay.
- Program overrun: if pc reaches PROGRAM_LENGTH while in FETCH, it is an error.
- Any error: error=1, result=0, go to IDLE in the same cycle.
- Cycle costs: a push takes 2 cycles; END takes 2 cycles; an OP takes 4 cycles plus the ALU busy time (add/sub: 5 cycles total).
- Arithmetic: none performed locally; overflow and saturation behaviour is the ALU's.

Optional Feature:
- Macro: RPN_EVALUATOR_CYCLE_COUNT_EN.
- With it defined:
  - Adds output cycle_count[15:0].
  - Counter clears on accepted start and increments every non-IDLE cycle, saturating at 16'hFFFF.
  - Holds its value in IDLE; reset value 0.
- Without it: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Program "PUSH_X, PUSH_CONST 0x0100, OP add, END", x=0x0180 -> done low for exactly 11 cycles, result=0x0280, error=0, alu_start pulsed once.
- Program "PUSH_X, PUSH_CONST 0x0200, OP mul, END", x=0x0180 -> result=0x0300; alu_a/alu_b/alu_op stay stable until alu_done returns high.
- Program "OP add, END" -> error=1, result=0, done high 2 cycles after start; no alu_start issued.
- STACK_DEPTH=8, nine PUSH_CONST tokens -> error at the 9th DECODE; program "PUSH_X, PUSH_X, OP 100, END" -> error=1 (illegal op).
- Assert rst_n low while in ALU_WAIT of a div -> all outputs reset immediately. Next start waits in ALU_ISSUE until alu_done=1, then evaluates correctly.
- With RPN_EVALUATOR_CYCLE_COUNT_EN defined, the first program -> cycle_count=11; start pulsed while busy is ignored (the count is unaffected).
